// File: rtl/bist_sig_engine.sv
// bist_sig_engine: multi-lane MISR signature compactor with golden compare.
// Optional compaction watchdog is built when BIST_SIG_WATCHDOG_EN is defined.
module bist_sig_engine #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 2,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(32'h80200003),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(32'h0000ACE1),
  parameter int unsigned TEST_LEN = 256,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   data_valid,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic [LANES-1:0]       carry_in,
  input  logic [LANES*WIDTH-1:0] golden_sig,
  input  logic                   clear_fault,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [LANES-1:0]       fault_mask,
  output logic                   mux_sel
);

  typedef enum logic [2:0] {
    IDLE,
    SEED_ST,
    COMPACT,
    COMPARE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] sig_q   [LANES];
  logic [WIDTH-1:0] sig_nxt [LANES];
  logic [LANES-1:0] mism;
  logic [LANES-1:0] fault_q;
  logic [15:0]      beat_q;
  logic             last_beat;

  logic load_seed;
  logic accept;
  logic do_cmp;
  logic clr_ok;

  assign last_beat = (beat_q == 16'(TEST_LEN - 1));

`ifdef BIST_SIG_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] idle_q;
  logic           wd_hit;

  // Counts consecutive stalled compaction cycles only.
  assign wd_hit = (state_q == COMPACT) && !data_valid &&
                  (idle_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else if (state_q != COMPACT || data_valid) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = SEED_ST;
      end
      SEED_ST: begin
        state_d = COMPACT;
      end
      COMPACT: begin
        if (data_valid && last_beat) begin
          state_d = COMPARE;
        end
`ifdef BIST_SIG_WATCHDOG_EN
        else if (wd_hit) begin
          state_d = DONE;
        end
`endif
      end
      COMPARE: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    load_seed = 1'b0;
    accept    = 1'b0;
    do_cmp    = 1'b0;
    clr_ok    = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_ok = 1'b1;
      end
      SEED_ST: begin
        busy      = 1'b1;
        load_seed = 1'b1;
      end
      COMPACT: begin
        busy   = 1'b1;
        accept = data_valid;
      end
      COMPARE: begin
        busy   = 1'b1;
        do_cmp = 1'b1;
      end
      DONE: begin
        done   = 1'b1;
        clr_ok = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_comb begin
    mism = '0;
    for (int i = 0; i < LANES; i++) begin
      sig_nxt[i] = {sig_q[i][WIDTH-2:0], ^(sig_q[i] & POLY)}
                 ^ data_in[i*WIDTH +: WIDTH]
                 ^ WIDTH'(carry_in[i]);
      mism[i] = (sig_q[i] != golden_sig[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        sig_q[i] <= SEED;
      end
      beat_q <= '0;
    end else if (load_seed) begin
      for (int i = 0; i < LANES; i++) begin
        sig_q[i] <= SEED;
      end
      beat_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        sig_q[i] <= sig_nxt[i];
      end
      beat_q <= beat_q + 16'd1;
    end
  end

  // Fault flags are sticky; only an explicit clear at rest drops them.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= '0;
      pass    <= 1'b0;
    end else if (do_cmp) begin
      fault_q <= fault_q | mism;
      pass    <= ~|mism;
    end
`ifdef BIST_SIG_WATCHDOG_EN
    else if (wd_hit) begin
      fault_q <= '1;
      pass    <= 1'b0;
    end
`endif
    else if (clr_ok && clear_fault) begin
      fault_q <= '0;
    end
  end

  assign fault_mask = fault_q;
  assign mux_sel    = |fault_q;

endmodule
